user_au_stream_source: RTL and testbench

- OBI-programmable audio sample source that feeds a valid/ready sample stream, such as the input of the LPF cascade.
- Software pushes signed 32-bit samples into an internal FIFO over OBI.
- A programmable sample-rate divider releases one sample per period onto data_o/valid_o, with ready_i backpressure.
- It is the producer end of the audio stream protocol.

---
 rtl/user_au_stream_source.sv | 186 ++++++++++++++++++
 tb/tb_user_au_stream_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_au_stream_source.sv
// OBI-programmable audio sample source: software fills a sample FIFO, a
// programmable divider releases one signed 32-bit sample per period onto a valid/ready stream.
package user_au_stream_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_au_stream_source #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 1041,
    parameter type obi_req_t = user_au_stream_pkg::obi_req_t,
    parameter type obi_rsp_t = user_au_stream_pkg::obi_rsp_t
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  obi_req_t           obi_req_i,
    output obi_rsp_t           obi_rsp_o,
    output logic signed [31:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [8:0]  DEPTH_L = 9'(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_DIV    = 2'd2;
    localparam logic [1:0] SEL_DATA   = 2'd3;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [8:0]    count;
    logic          en_q;
    logic [15:0]   div_q, cnt_q;
    logic          underrun_q, late_q, overflow_q;
    logic          valid_q;
    logic [31:0]   data_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q, rdata_d;

    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        wr_en, rd_en, ctrl_wr, status_wr, div_wr, data_wr;
    logic        flush, tick, out_free, load, empty, full, pop, push_ok;
    logic        underrun_set, late_set, overflow_set;
    logic [31:0] status;
    logic        unused_obi;

    assign sel       = obi_req_i.a.addr[3:2];
    assign wdata     = obi_req_i.a.wdata;
    assign wr_en     = obi_req_i.req & obi_req_i.a.we;
    assign rd_en     = obi_req_i.req & ~obi_req_i.a.we;
    assign ctrl_wr   = wr_en & (sel == SEL_CTRL);
    assign status_wr = wr_en & (sel == SEL_STATUS);
    assign div_wr    = wr_en & (sel == SEL_DIV);
    assign data_wr   = wr_en & (sel == SEL_DATA);
    assign unused_obi = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0], obi_req_i.a.be};

    assign flush    = ctrl_wr & wdata[1];
    assign empty    = (count == 9'd0);
    assign full     = (count == DEPTH_L);
    assign tick     = en_q & (cnt_q == div_q);
    assign out_free = ~valid_q | ready_i;
    assign load     = tick & out_free;
    assign pop      = load & ~empty;
    // Room is judged after a same-cycle pop; a flush always beats a push.
    assign push_ok      = data_wr & ~flush & (~full | pop);
    assign overflow_set = data_wr & ~flush & full & ~pop;
    assign underrun_set = load & empty;
    assign late_set     = tick & ~out_free;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // A same-cycle pop still reads mem[rd_ptr] before the pointers realign.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + 9'(push_ok) - 9'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!en_q || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= empty ? 32'd0 : mem[rd_ptr];
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            div_q      <= DIV_RST;
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (ctrl_wr) en_q  <= wdata[0];
            if (div_wr)  div_q <= wdata[15:0];
            // Sticky sets win over a simultaneous W1C.
            underrun_q <= (underrun_q & ~(status_wr & wdata[10])) | underrun_set;
            late_q     <= (late_q     & ~(status_wr & wdata[11])) | late_set;
            overflow_q <= (overflow_q & ~(status_wr & wdata[12])) | overflow_set;
        end
    end

    assign status = {18'd0, full, overflow_q, late_q, underrun_q, empty, count};

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (sel)
                SEL_CTRL:   rdata_d = {31'd0, en_q};
                SEL_STATUS: rdata_d = status;
                SEL_DIV:    rdata_d = {16'd0, div_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.err   = 1'b0;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: tb/tb_user_au_stream_source.sv
// Directed bench for user_au_stream_source: a queue-based model of the FIFO,
// divider and output slot is compared against the DUT on every cycle.
module tb_user_au_stream_source;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    user_au_stream_pkg::obi_req_t req;
    user_au_stream_pkg::obi_rsp_t rsp;
    logic signed [31:0] data_o;
    logic valid_o;
    logic ready;

    user_au_stream_source #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(1041)) dut (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req), .obi_rsp_o(rsp),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] last_rdata;
    logic [31:0] hs_q[$];
    int          hs_cyc[$];

    // Model state
    logic [31:0] mq[$];
    logic        m_en;
    logic [15:0] m_div;
    int          m_cnt;
    logic        m_vld;
    logic [31:0] m_dat;
    logic        m_unr, m_late, m_ovf;
    logic        m_rv;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_div = 16'd1041; m_cnt = 0;
        m_vld = 0; m_dat = 0;
        m_unr = 0; m_late = 0; m_ovf = 0;
        m_rv = 0; m_rd = 0;
    endtask

    function automatic logic [31:0] mread(input logic [1:0] sel);
        int lvl;
        lvl = mq.size();
        case (sel)
            2'd0: return {31'd0, m_en};
            2'd1: return 32'(lvl) | ((lvl == 0) ? 32'h200 : 0) | (m_unr ? 32'h400 : 0)
                         | (m_late ? 32'h800 : 0) | (m_ovf ? 32'h1000 : 0)
                         | ((lvl == DEPTH) ? 32'h2000 : 0);
            2'd2: return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_next();
        logic        tick, wr;
        logic [1:0]  sel;
        logic [31:0] wd, rd_n;
        tick = m_en && (m_cnt == int'(m_div));
        wr   = req.req && req.a.we;
        sel  = req.a.addr[3:2];
        wd   = req.a.wdata;
        rd_n = (req.req && !req.a.we) ? mread(sel) : 32'd0;
        if (!m_en || tick) m_cnt = 0; else m_cnt = (m_cnt + 1) % 65536;
        if (wr && sel == 2'd1) begin
            if (wd[10]) m_unr = 0;
            if (wd[11]) m_late = 0;
            if (wd[12]) m_ovf = 0;
        end
        if (tick && (!m_vld || ready)) begin
            if (mq.size() > 0) m_dat = mq.pop_front();
            else begin m_dat = 0; m_unr = 1; end
            m_vld = 1;
        end else if (tick) m_late = 1;
        else if (m_vld && ready) m_vld = 0;
        if (wr) begin
            case (sel)
                2'd0: begin m_en = wd[0]; if (wd[1]) mq.delete(); end
                2'd2: m_div = wd[15:0];
                2'd3: if (mq.size() < DEPTH) mq.push_back(wd); else m_ovf = 1;
                default: ;
            endcase
        end
        m_rv = req.req;
        m_rd = rd_n;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        chk("gnt", {31'd0, rsp.gnt}, {31'd0, req.req});
        chk("valid_o", {31'd0, valid_o}, {31'd0, m_vld});
        if (m_vld) chk("data_o", data_o, m_dat);
        chk("rvalid", {31'd0, rsp.rvalid}, {31'd0, m_rv});
        if (m_rv) begin
            chk("rdata", rsp.r.rdata, m_rd);
            chk("err", {31'd0, rsp.r.err}, 32'd0);
        end
        if (rsp.rvalid) last_rdata = rsp.r.rdata;
        if (valid_o && ready) begin hs_q.push_back(data_o); hs_cyc.push_back(cyc); end
        if (!rst_n) model_reset(); else model_next();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic obi_wr(input logic [1:0] sel, input logic [31:0] d);
        req = '0;
        req.req = 1; req.a.addr = {28'd0, sel, 2'b00}; req.a.we = 1; req.a.be = 4'hF; req.a.wdata = d;
        step();
        req = '0;
    endtask

    task automatic obi_rd(input logic [1:0] sel, output logic [31:0] v);
        req = '0;
        req.req = 1; req.a.addr = {28'd0, sel, 2'b00}; req.a.we = 0; req.a.be = 4'hF;
        step();
        req = '0;
        step();
        v = last_rdata;
    endtask

    function automatic logic [31:0] hs_at(input int i);
        return (i < hs_q.size()) ? hs_q[i] : 32'hDEADBEEF;
    endfunction

    function automatic int hs_gap(input int i);
        return (i + 1 < hs_cyc.size()) ? hs_cyc[i+1] - hs_cyc[i] : -1;
    endfunction

    initial begin
        logic [31:0] v;
        rst_n = 0; ready = 0; req = '0;
        model_reset();
        repeat (2) step();
        rst_n = 1;
        step();

        // 1: reset values
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        obi_rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
        obi_rd(2'd1, v); chk("rst_status", v, 32'h200);
        obi_rd(2'd2, v); chk("rst_div", v, 32'd1041);
        obi_rd(2'd3, v); chk("data_read_zero", v, 32'd0);

        // 2: DIV=3, three samples then silence
        obi_wr(2'd2, 32'd3);
        obi_wr(2'd3, 32'h00000001);
        obi_wr(2'd3, 32'h7FFFFFFF);
        obi_wr(2'd3, 32'h80000000);
        ready = 1;
        hs_q.delete(); hs_cyc.delete();
        obi_wr(2'd0, 32'd1);
        repeat (20) step();
        chk("seq_s0", hs_at(0), 32'h00000001);
        chk("seq_s1", hs_at(1), 32'h7FFFFFFF);
        chk("seq_s2", hs_at(2), 32'h80000000);
        chk("seq_s3_silence", hs_at(3), 32'd0);
        chk("seq_gap01", 32'(hs_gap(0)), 32'd4);
        chk("seq_gap12", 32'(hs_gap(1)), 32'd4);
        chk("seq_gap23", 32'(hs_gap(2)), 32'd4);
        obi_rd(2'd1, v); chk("underrun_status", v, 32'h600);
        obi_wr(2'd0, 32'd0);
        obi_wr(2'd1, 32'h1C00);
        step();

        // 3: DIV=0 with backpressure
        obi_wr(2'd2, 32'd0);
        obi_wr(2'd3, 32'h11);
        obi_wr(2'd3, 32'h22);
        ready = 0;
        obi_wr(2'd0, 32'd1);
        repeat (6) step();
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_data", data_o, 32'h11);
        hs_q.delete(); hs_cyc.delete();
        ready = 1;
        step();
        step();
        chk("bp_s0", hs_at(0), 32'h11);
        chk("bp_s1", hs_at(1), 32'h22);
        chk("bp_nogap", 32'(hs_gap(0)), 32'd1);
        obi_wr(2'd0, 32'd0);
        step();
        obi_rd(2'd1, v); chk("late_bit", {31'd0, v[11]}, 32'd1);
        obi_wr(2'd1, 32'h1C00);

        // 4: overflow with EN=0
        for (int i = 0; i < DEPTH + 2; i++) obi_wr(2'd3, 32'h1000 + 32'(i));
        obi_rd(2'd1, v); chk("full_status", v, 32'h3010);
        obi_wr(2'd1, 32'h1000);
        obi_rd(2'd1, v); chk("ovf_w1c", v, 32'h2010);

        // 5: flush keeps a pending output sample
        obi_wr(2'd0, 32'd2);
        obi_rd(2'd1, v); chk("flush_empty", v, 32'h200);
        for (int i = 0; i < 6; i++) obi_wr(2'd3, 32'h100 + 32'(i));
        ready = 0;
        obi_wr(2'd0, 32'd1);
        step();
        step();
        obi_wr(2'd0, 32'd3);
        obi_rd(2'd1, v); chk("flush_lvl", {22'd0, v[9:0]}, 32'h200);
        chk("flush_keep_valid", {31'd0, valid_o}, 32'd1);
        chk("flush_keep_data", data_o, 32'h100);
        hs_q.delete(); hs_cyc.delete();
        ready = 1;
        step();
        chk("flush_hs", hs_at(0), 32'h100);
        obi_wr(2'd0, 32'd0);
        step();
        step();

        // 6: reset mid-stream
        obi_wr(2'd1, 32'h1C00);
        ready = 0;
        for (int i = 0; i < 8; i++) obi_wr(2'd3, 32'h200 + 32'(i));
        obi_wr(2'd0, 32'd1);
        step();
        obi_rd(2'd1, v); chk("pre_rst_lvl", {23'd0, v[8:0]}, 32'd7);
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async_valid", {31'd0, valid_o}, 32'd0);
        chk("async_data", data_o, 32'd0);
        chk("async_rvalid", {31'd0, rsp.rvalid}, 32'd0);
        model_reset();
        step();
        step();
        rst_n = 1;
        step();
        obi_rd(2'd0, v); chk("post_rst_ctrl", v, 32'd0);
        obi_rd(2'd1, v); chk("post_rst_status", v, 32'h200);
        obi_rd(2'd2, v); chk("post_rst_div", v, 32'd1041);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
